hc595_chain_driver: RTL and testbench
=====================================

Name: hc595_chain_driver

Overview:
Parametrised serial driver for a daisy-chain of CHIPS 74HC595 shift registers (segment/digit drivers of the LED7seg board).
- Accepts one full-chain frame per valid/ready handshake.
- Shifts the frame out with programmable SRCLK timing and bit order, then pulses RCLK to latch all chips at once.
- Sits between the display scan/counter logic and the board pins.

Parameters:
- CHIPS, 4, number of cascaded 74HC595 devices; legal range 1..16. Frame width W = 8*CHIPS (localparam).
- HALF_PERIOD, 200, clk cycles per SRCLK low phase (data setup), per SRCLK high phase, and per RCLK high pulse; must be >= 1.
- MSB_FIRST, 1, 1: in_data[W-1] is shifted first; 0: in_data[0] is shifted first.

Ports:
- clk  input  1  system clock (100 MHz).
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  frame offered.
- in_data  input  W  frame; in_data[8k+7:8k] ends in chip k when MSB_FIRST=1 (chip 0 is nearest the FPGA).
- in_ready  output  1  driver can accept a frame.
- busy  output  1  a frame is being shifted or latched.
- done  output  1  one-cycle pulse when the latch completes.
- SRCLK  output  1  shift clock (SH_CP).
- RCLK  output  1  storage/latch clock (ST_CP).
- SER  output  1  serial data (DS).

Behaviour:
- All outputs are registered. Reset values: SRCLK=0, RCLK=0, SER=0, in_ready=1, busy=0, done=0. Reset places the FSM in IDLE and clears the timer and bit counter.
- FSM states:
  - IDLE: in_ready=1. When in_valid&&in_ready at edge t, capture in_data into the W-bit shift register, clear the bit count, and go to SETUP. From t+1: in_ready=0, busy=1.
  - SETUP: SRCLK=0. SER = current bit (shreg MSB or LSB per MSB_FIRST) from the first SETUP cycle. Stay for HALF_PERIOD cycles, then go to HIGH.
  - HIGH: SRCLK=1 and SER held for HALF_PERIOD cycles. On exit, shift the register by one and increment the count.
    - count reaches W: go to LATCH.
    - otherwise: go to SETUP.
  - LATCH: SRCLK=0, SER=0, RCLK=1 for HALF_PERIOD cycles. On exit: RCLK=0, done=1 for one cycle, busy=0, in_ready=1, go to IDLE.
- Timing:
  - SER changes only while SRCLK=0, never on the cycle SRCLK rises.
  - Each bit occupies exactly 2*HALF_PERIOD cycles.
  - done rises at cycle t+1+2*HALF_PERIOD*W+HALF_PERIOD.
  - Exactly W SRCLK rising edges and one RCLK rising edge per frame.
- Handshake:
  - in_data is sampled only at acceptance; later changes to in_data are ignored.
  - in_valid while busy is ignored. There is no queue, so the offering side must hold the frame.
  - Back-to-back: in_ready is high in the done cycle. If in_valid is also high in that cycle, the next frame is accepted and its SETUP starts the following cycle.
- Counters: the timer is clog2(HALF_PERIOD+1) bits wide. The bit counter is clog2(W+1) bits wide. Neither counter wraps.
- Reset mid-frame: the next edge forces reset values. No RCLK pulse is issued, so the 595 output registers keep the previously latched frame. The partial shift contents are overwritten by the next frame.
- rst has priority over in_valid in the same cycle.

Optional Feature:
- Macro HC595_OE_EN.
- When defined, the block adds:
  - input blank (1 bit).
  - output OE_N (1 bit, 74HC595 output enable, active-low).
- OE_N behaviour:
  - OE_N=1 from reset until the first done pulse.
  - After that, OE_N = blank, registered with 1-cycle latency.
  - Reset forces OE_N=1 again.
- When the macro is not defined: no blank/OE_N ports, and the board ties OE low.

Test Plan:
- CHIPS=1, HALF_PERIOD=2, MSB_FIRST=1, frame 8'hA5 accepted at t.
  - SER samples at the 8 SRCLK rises = 1,0,1,0,0,1,0,1.
  - RCLK high cycles t+33..t+34.
  - done at t+35, in_ready at t+35.
- Same setup with MSB_FIRST=0, frame 8'hA5 -> SER at rises = 1,0,1,0,0,1,0,1 reversed = 1,0,1,0,0,1,0,1, i.e. in_data[0] first. Also check frame 8'h01 -> first rise SER=1, rest 0.
- CHIPS=2, HALF_PERIOD=1, 16'h8001 -> 16 SRCLK rises, first and last SER=1, done at t+1+32+1=t+34. Shadow 595 model shows chip1=8'h80, chip0=8'h01.
- in_valid held high with new data during busy -> data ignored. in_valid high in the done cycle -> second frame accepted, first SETUP cycle at done+1.
- rst asserted at bit 5 -> next cycle all outputs at reset values, no RCLK pulse. A new frame then completes normally.
- HC595_OE_EN: OE_N=1 after reset, 0 one cycle after the first done with blank=0, 1 one cycle after blank=1.

Source files
------------

// File: rtl/hc595_chain_driver_if.sv
// Frame handshake between the display scan logic and the 74HC595 chain driver.
// The master offers a full-chain frame; the slave (driver) accepts it with in_ready.
interface hc595_chain_driver_if #(
    parameter int W = 32
) ();
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/hc595_chain_driver.sv
// Serial driver for a daisy-chain of CHIPS 74HC595 devices: shifts one frame out on SER/SRCLK, then latches it with RCLK.
// Optional output-enable control (blank input, OE_N output) is built when HC595_OE_EN is defined.
//
// state | meaning
// IDLE  | waiting for a frame, in_ready high
// SETUP | SRCLK low, SER presents the current bit
// HIGH  | SRCLK high, SER held; shift on exit
// LATCH | RCLK high, transfers the chain to the 595 outputs
module hc595_chain_driver #(
    parameter int CHIPS       = 4,
    parameter int HALF_PERIOD = 200,
    parameter int MSB_FIRST   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    hc595_chain_driver_if.slave        bus,
    output logic                       busy,
    output logic                       done,
    output logic                       SRCLK,
    output logic                       RCLK,
    output logic                       SER
`ifdef HC595_OE_EN
    ,
    input  logic                       blank,
    output logic                       OE_N
`endif
);

    localparam int W  = 8 * CHIPS;
    localparam int TW = $clog2(HALF_PERIOD + 1);
    localparam int CW = $clog2(W + 1);

    localparam logic [TW-1:0] T_LOAD = TW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] C_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LATCH = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [W-1:0]  shreg;
    logic [W-1:0]  shreg_nxt;
    logic          done_nxt;
    logic          ser_nxt;
    logic          tc;

    assign tc = (timer == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            cnt         <= '0;
            shreg       <= '0;
            SRCLK       <= 1'b0;
            RCLK        <= 1'b0;
            SER         <= 1'b0;
            bus.in_ready <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            cnt         <= cnt_nxt;
            shreg       <= shreg_nxt;
            // Outputs are registered from the next state so they line up with it.
            SRCLK       <= (state_nxt == HIGH);
            RCLK        <= (state_nxt == LATCH);
            SER         <= ser_nxt;
            bus.in_ready <= (state_nxt == IDLE);
            busy        <= (state_nxt != IDLE);
            done        <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (bus.in_valid && bus.in_ready) begin
                    shreg_nxt = bus.in_data;
                    cnt_nxt   = '0;
                    timer_nxt = T_LOAD;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (tc) begin
                    timer_nxt = T_LOAD;
                    state_nxt = HIGH;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            HIGH: begin
                if (tc) begin
                    timer_nxt = T_LOAD;
                    shreg_nxt = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
                    cnt_nxt   = cnt + 1'b1;
                    state_nxt = (cnt == C_LAST) ? LATCH : SETUP;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            LATCH: begin
                if (tc) begin
                    timer_nxt = '0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            default: begin
                timer_nxt = '0;
                state_nxt = IDLE;
            end
        endcase

        // SER only moves on entry to SETUP, so it is stable across the SRCLK rise.
        if ((state_nxt == SETUP) || (state_nxt == HIGH)) begin
            ser_nxt = (MSB_FIRST != 0) ? shreg_nxt[W-1] : shreg_nxt[0];
        end else begin
            ser_nxt = 1'b0;
        end
    end

`ifdef HC595_OE_EN
    logic oe_armed;

    // Outputs stay disabled until the chain holds a real frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            oe_armed <= 1'b0;
            OE_N     <= 1'b1;
        end else begin
            if (done) begin
                oe_armed <= 1'b1;
            end
            if (done || oe_armed) begin
                OE_N <= blank;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hc595_chain_driver.sv
// Directed bench for hc595_chain_driver: three parameterisations, a scoreboard of expected SER bits and a shadow 595 chain.
module tb_hc595_chain_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        tv;
    logic [15:0] td;
    int          sel;
    int          checks   = 0;
    int          failures = 0;
    logic        exp_q[$];

    always #5 clk = ~clk;

    hc595_chain_driver_if #(.W(8))  if_a ();
    hc595_chain_driver_if #(.W(8))  if_b ();
    hc595_chain_driver_if #(.W(16)) if_c ();

    assign if_a.in_valid = tv && (sel == 0);
    assign if_a.in_data  = td[7:0];
    assign if_b.in_valid = tv && (sel == 1);
    assign if_b.in_data  = td[7:0];
    assign if_c.in_valid = tv && (sel == 2);
    assign if_c.in_data  = td;

    logic busy_a, done_a, srclk_a, rclk_a, ser_a;
    logic busy_b, done_b, srclk_b, rclk_b, ser_b;
    logic busy_c, done_c, srclk_c, rclk_c, ser_c;
`ifdef HC595_OE_EN
    logic blank;
    logic oe_n_a, oe_n_b, oe_n_c;
`endif

    hc595_chain_driver #(.CHIPS(1), .HALF_PERIOD(2), .MSB_FIRST(1)) u_a (
        .clk(clk), .rst(rst), .bus(if_a), .busy(busy_a), .done(done_a),
        .SRCLK(srclk_a), .RCLK(rclk_a), .SER(ser_a)
`ifdef HC595_OE_EN
        , .blank(blank), .OE_N(oe_n_a)
`endif
    );

    hc595_chain_driver #(.CHIPS(1), .HALF_PERIOD(2), .MSB_FIRST(0)) u_b (
        .clk(clk), .rst(rst), .bus(if_b), .busy(busy_b), .done(done_b),
        .SRCLK(srclk_b), .RCLK(rclk_b), .SER(ser_b)
`ifdef HC595_OE_EN
        , .blank(blank), .OE_N(oe_n_b)
`endif
    );

    hc595_chain_driver #(.CHIPS(2), .HALF_PERIOD(1), .MSB_FIRST(1)) u_c (
        .clk(clk), .rst(rst), .bus(if_c), .busy(busy_c), .done(done_c),
        .SRCLK(srclk_c), .RCLK(rclk_c), .SER(ser_c)
`ifdef HC595_OE_EN
        , .blank(blank), .OE_N(oe_n_c)
`endif
    );

    logic m_ready, m_busy, m_done, m_srclk, m_rclk, m_ser;

    always_comb begin
        m_ready = if_a.in_ready;
        m_busy  = busy_a;
        m_done  = done_a;
        m_srclk = srclk_a;
        m_rclk  = rclk_a;
        m_ser   = ser_a;
        case (sel)
            1: begin
                m_ready = if_b.in_ready; m_busy = busy_b; m_done = done_b;
                m_srclk = srclk_b; m_rclk = rclk_b; m_ser = ser_b;
            end
            2: begin
                m_ready = if_c.in_ready; m_busy = busy_c; m_done = done_c;
                m_srclk = srclk_c; m_rclk = rclk_c; m_ser = ser_c;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_srclk"}, 32'(m_srclk), 32'd0);
        chk({tag, "_rclk"},  32'(m_rclk),  32'd0);
        chk({tag, "_ser"},   32'(m_ser),   32'd0);
        chk({tag, "_ready"}, 32'(m_ready), 32'd1);
        chk({tag, "_busy"},  32'(m_busy),  32'd0);
        chk({tag, "_done"},  32'(m_done),  32'd0);
    endtask

    task automatic start_frame(input logic [15:0] data);
        @(negedge clk);
        tv = 1'b1;
        td = data;
        @(posedge clk);
    endtask

    // Observes one frame from the cycle after its acceptance edge until done.
    task automatic watch_frame(input logic [15:0] data, input bit hold, input logic [15:0] nd,
                               input int abort_rise);
        int          w, hp, cyc, rises, rclk_hi, rclk_first, rclk_edges, done_cyc, budget;
        bit          msb, fin;
        logic        prev_srclk, prev_rclk, prev_ser;
        logic [15:0] sh, lat, expl, mask;

        w    = (sel == 2) ? 16 : 8;
        hp   = (sel == 2) ? 1 : 2;
        msb  = (sel != 1);
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        expl = '0;
        for (int i = 0; i < w; i++) begin
            exp_q.push_back(data[msb ? (w - 1 - i) : i]);
            expl[i] = msb ? data[i] : data[w - 1 - i];
        end

        prev_srclk = 1'b0; prev_rclk = 1'b0; prev_ser = 1'b0;
        cyc = 0; rises = 0; rclk_hi = 0; rclk_first = 0; rclk_edges = 0; done_cyc = 0;
        fin = 1'b0; sh = '0; lat = '0;
        budget = 2 * hp * w + hp + 20;

        while (!fin && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                if (hold) td = nd;
                else      tv = 1'b0;
                chk("accept_busy",  32'(m_busy),  32'd1);
                chk("accept_ready", 32'(m_ready), 32'd0);
            end
            if (!prev_srclk && m_srclk) begin
                rises++;
                chk("ser_stable_at_rise", 32'(m_ser), 32'(prev_ser));
                if (exp_q.size() > 0) chk("ser_bit", 32'(m_ser), 32'(exp_q.pop_front()));
                else                  chk("extra_rise", 32'(rises), 32'(w));
                sh = ((sh << 1) | 16'(m_ser)) & mask;
            end
            if (m_rclk) begin
                if (!prev_rclk) begin
                    lat = sh;
                    rclk_edges++;
                    if (rclk_first == 0) rclk_first = cyc;
                end
                rclk_hi++;
            end
            if (m_done) begin
                done_cyc = cyc;
                fin      = 1'b1;
                chk("ready_in_done_cycle", 32'(m_ready), 32'd1);
                chk("busy_in_done_cycle",  32'(m_busy),  32'd0);
            end
            if (abort_rise > 0 && rises == abort_rise) begin
                rst = 1'b1;
                tv  = 1'b1;
                @(negedge clk);
                check_reset_values("abort");
                chk("abort_no_rclk", 32'(rclk_edges), 32'd0);
                rst = 1'b0;
                tv  = 1'b0;
                exp_q.delete();
                return;
            end
            prev_srclk = m_srclk;
            prev_rclk  = m_rclk;
            prev_ser   = m_ser;
        end

        chk("done_seen", 32'(fin), 32'd1);
        if (fin) begin
            chk("srclk_rises",  32'(rises),      32'(w));
            chk("rclk_edges",   32'(rclk_edges), 32'd1);
            chk("rclk_first",   32'(rclk_first), 32'(2 * hp * w + 1));
            chk("rclk_width",   32'(rclk_hi),    32'(hp));
            chk("done_cycle",   32'(done_cyc),   32'(2 * hp * w + hp + 1));
            chk("latched",      32'(lat),        32'(expl));
            chk("queue_empty",  32'(exp_q.size()), 32'd0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        tv  = 1'b0;
        td  = '0;
        sel = 0;
`ifdef HC595_OE_EN
        blank = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_reset_values("reset");
`ifdef HC595_OE_EN
        chk("oe_after_reset", 32'(oe_n_a), 32'd1);
`endif
        rst = 1'b0;

        // MSB first, 8'hA5
        start_frame(16'h00A5);
        watch_frame(16'h00A5, 1'b0, 16'h0000, 0);
        @(negedge clk);
        chk("done_one_cycle", 32'(m_done), 32'd0);
`ifdef HC595_OE_EN
        chk("oe_after_first_done", 32'(oe_n_a), 32'd0);
        blank = 1'b1;
        @(negedge clk);
        chk("oe_blanked", 32'(oe_n_a), 32'd1);
        blank = 1'b0;
`endif

        // new data offered while busy is ignored, then accepted in the done cycle
        start_frame(16'h003C);
        watch_frame(16'h003C, 1'b1, 16'h00C3, 0);
        watch_frame(16'h00C3, 1'b0, 16'h0000, 0);

        // reset after the fifth bit, with in_valid high alongside it
        start_frame(16'h005A);
        watch_frame(16'h005A, 1'b0, 16'h0000, 5);
`ifdef HC595_OE_EN
        chk("oe_after_abort_reset", 32'(oe_n_a), 32'd1);
`endif
        start_frame(16'h0081);
        watch_frame(16'h0081, 1'b0, 16'h0000, 0);

        // LSB first
        @(negedge clk);
        sel = 1;
        start_frame(16'h00A5);
        watch_frame(16'h00A5, 1'b0, 16'h0000, 0);
        start_frame(16'h0001);
        watch_frame(16'h0001, 1'b0, 16'h0000, 0);

        // two chips, HALF_PERIOD=1
        @(negedge clk);
        sel = 2;
        start_frame(16'h8001);
        watch_frame(16'h8001, 1'b0, 16'h0000, 0);
        start_frame(16'h3CA7);
        watch_frame(16'h3CA7, 1'b0, 16'h0000, 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
